// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, ALU control encoding and payload types for alu_issue.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int C_XLEN = 16;

    // Instruction opcodes (instr[15:11])
    localparam logic [4:0] C_OPC_R_ARITH = 5'b11011;
    localparam logic [4:0] C_OPC_R_SHIFT = 5'b11010;
    localparam logic [4:0] C_OPC_SEQ     = 5'b11100;
    localparam logic [4:0] C_OPC_SLT     = 5'b11101;
    localparam logic [4:0] C_OPC_SLE     = 5'b11110;
    localparam logic [4:0] C_OPC_SCO     = 5'b11111;
    localparam logic [4:0] C_OPC_ADDI    = 5'b01000;
    localparam logic [4:0] C_OPC_SUBI    = 5'b01001;
    localparam logic [4:0] C_OPC_XORI    = 5'b01010;
    localparam logic [4:0] C_OPC_ANDNI   = 5'b01011;
    localparam logic [4:0] C_OPC_ROLI    = 5'b10100;
    localparam logic [4:0] C_OPC_SLLI    = 5'b10101;
    localparam logic [4:0] C_OPC_RORI    = 5'b10110;
    localparam logic [4:0] C_OPC_SRLI    = 5'b10111;

    // ALU opcodes
    localparam logic [3:0] C_ALU_ROL = 4'b0000;
    localparam logic [3:0] C_ALU_ROR = 4'b0001;
    localparam logic [3:0] C_ALU_SLL = 4'b0010;
    localparam logic [3:0] C_ALU_SRL = 4'b0100;
    localparam logic [3:0] C_ALU_ADD = 4'b1000;
    localparam logic [3:0] C_ALU_XOR = 4'b1010;
    localparam logic [3:0] C_ALU_AND = 4'b1011;
    localparam logic [3:0] C_ALU_SCO = 4'b1100;
    localparam logic [3:0] C_ALU_SLE = 4'b1101;
    localparam logic [3:0] C_ALU_SLT = 4'b1110;
    localparam logic [3:0] C_ALU_SEQ = 4'b1111;

    typedef struct packed {
        logic [3:0] op;
        logic       inv_a;
        logic       inv_b;
        logic       cin;
        logic       sign;
    } alu_ctl_t;

    typedef struct packed {
        alu_ctl_t          ctl;
        logic [C_XLEN-1:0] a;
        logic [C_XLEN-1:0] b;
        logic              wr_en;
        logic [2:0]        wr_reg;
        logic              illegal;
    } alu_issue_pl_t;

    // R-format funct and the low bits of the shift-immediate opcodes share this order
    function automatic logic [3:0] shift_op(input logic [1:0] sel);
        case (sel)
            2'b00:   shift_op = C_ALU_ROL;
            2'b01:   shift_op = C_ALU_SLL;
            2'b10:   shift_op = C_ALU_ROR;
            default: shift_op = C_ALU_SRL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_decode
// Brief    : Combinational decode of an ALU-class instruction into the ALU
//            control word, operands and writeback info.
// Revision : 1.0
// ============================================================================
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [15:0] instr,
    input  logic [15:0] rs_data,
    input  logic [15:0] rt_data,
    output alu_ctl_t    ctl,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic        wr_en,
    output logic [2:0]  wr_reg,
    output logic        illegal
);

    logic [4:0]  w_opc;
    logic [15:0] w_imm_sext;
    logic [15:0] w_imm_zext;
    logic [15:0] w_imm_shamt;

    assign w_opc       = instr[15:11];
    assign w_imm_sext  = {{11{instr[4]}}, instr[4:0]};
    assign w_imm_zext  = {11'b0, instr[4:0]};
    assign w_imm_shamt = {12'b0, instr[3:0]};

    always_comb begin
        ctl     = '0;
        ctl.op  = C_ALU_ADD;
        a       = '0;
        b       = '0;
        wr_en   = 1'b0;
        wr_reg  = 3'd0;
        illegal = 1'b0;
        case (w_opc)
            C_OPC_R_ARITH: begin
                a      = rs_data;
                b      = rt_data;
                wr_en  = 1'b1;
                wr_reg = instr[4:2];
                case (instr[1:0])
                    2'b00: ctl.sign = 1'b1;
                    2'b01: begin
                        ctl.inv_a = 1'b1;
                        ctl.cin   = 1'b1;
                        ctl.sign  = 1'b1;
                    end
                    2'b10: ctl.op = C_ALU_XOR;
                    default: begin
                        ctl.op    = C_ALU_AND;
                        ctl.inv_b = 1'b1;
                    end
                endcase
            end
            C_OPC_R_SHIFT, C_OPC_SEQ, C_OPC_SLT, C_OPC_SLE, C_OPC_SCO: begin
                a      = rs_data;
                b      = rt_data;
                wr_en  = 1'b1;
                wr_reg = instr[4:2];
                case (w_opc)
                    C_OPC_SEQ: ctl.op = C_ALU_SEQ;
                    C_OPC_SLT: ctl.op = C_ALU_SLT;
                    C_OPC_SLE: ctl.op = C_ALU_SLE;
                    C_OPC_SCO: ctl.op = C_ALU_SCO;
                    default:   ctl.op = shift_op(instr[1:0]);
                endcase
            end
            C_OPC_ADDI, C_OPC_SUBI: begin
                a         = rs_data;
                b         = w_imm_sext;
                wr_en     = 1'b1;
                wr_reg    = instr[7:5];
                ctl.sign  = 1'b1;
                ctl.inv_a = w_opc[0];
                ctl.cin   = w_opc[0];
            end
            C_OPC_XORI, C_OPC_ANDNI: begin
                a         = rs_data;
                b         = w_imm_zext;
                wr_en     = 1'b1;
                wr_reg    = instr[7:5];
                ctl.op    = w_opc[0] ? C_ALU_AND : C_ALU_XOR;
                ctl.inv_b = w_opc[0];
            end
            C_OPC_ROLI, C_OPC_SLLI, C_OPC_RORI, C_OPC_SRLI: begin
                a      = rs_data;
                b      = w_imm_shamt;
                wr_en  = 1'b1;
                wr_reg = instr[7:5];
                ctl.op = shift_op(w_opc[1:0]);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : Execute-stage issue register: valid/ready pipeline stage holding
//            the decoded ALU control word and operands. ALU_ISSUE_SKID_EN
//            adds a one-entry skid buffer with a registered in_ready.
// Revision : 1.0
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic             alu_inv_a,
    output logic             alu_inv_b,
    output logic             alu_cin,
    output logic             alu_sign,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             wr_en,
    output logic [2:0]       wr_reg,
    output logic             illegal
);

    alu_issue_pl_t w_dec;
    alu_issue_pl_t r_out;
    logic          r_out_valid;
    logic          w_load;

    alu_issue_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .ctl     (w_dec.ctl),
        .a       (w_dec.a),
        .b       (w_dec.b),
        .wr_en   (w_dec.wr_en),
        .wr_reg  (w_dec.wr_reg),
        .illegal (w_dec.illegal)
    );

`ifdef ALU_ISSUE_SKID_EN
    alu_issue_pl_t r_skid;
    logic          r_skid_valid;
    logic          r_in_ready;
    logic          w_out_free;

    assign in_ready   = r_in_ready;
    assign w_load     = in_valid & r_in_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_free) begin
            // A full skid means in_ready was low, so no load can collide here
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid <= w_load;
                if (w_load) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_load) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;
    assign w_load   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign alu_op    = r_out.ctl.op;
    assign alu_inv_a = r_out.ctl.inv_a;
    assign alu_inv_b = r_out.ctl.inv_b;
    assign alu_cin   = r_out.ctl.cin;
    assign alu_sign  = r_out.ctl.sign;
    assign alu_a     = r_out.a;
    assign alu_b     = r_out.b;
    assign wr_en     = r_out.wr_en;
    assign wr_reg    = r_out.wr_reg;
    assign illegal   = r_out.illegal;

endmodule
`default_nettype wire
